// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Holds the FSM state encoding, the wait-counter width helper and the NOP encoding.
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    HALT     = 2'd2
  } ctrl_state_e;

  // addi x0, x0, 0 -- what a flushed IF/ID slot decodes as
  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  // Width of the MEM_WAIT cycle counter; never narrower than one bit
  function automatic int wait_cnt_width(input int max_wait);
    return (max_wait < 2) ? 1 : $clog2(max_wait);
  endfunction

endpackage : pipeline_ctrl_pkg

// File: rtl/hazard_sat_counter.sv
// Saturating up-counter used for the stall/flush performance counters.
// Holds at all-ones instead of wrapping.
module hazard_sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {W{1'b1}})) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule : hazard_sat_counter

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage core: load-use bubbles,
// taken-branch flushes, data-memory wait freeze with timeout, and perf counters.
module pipeline_hazard_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int MAX_WAIT = 16,
  parameter int COUNT_W  = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [4:0]         id_rs1,
  input  logic [4:0]         id_rs2,
  input  logic               id_uses_rs2,
  input  logic               ie_memread,
  input  logic [4:0]         ie_rd,
  input  logic               em_branch,
  input  logic               em_zero,
  input  logic               em_mem_access,
  input  logic               dmem_ready,
  output logic               pc_write,
  output logic               pc_sel_branch,
  output logic               if_id_write,
  output logic               if_id_flush,
  output logic               id_ex_write,
  output logic               id_ex_flush,
  output logic               ex_mem_write,
  output logic               ex_mem_flush,
  output logic               mem_wb_write,
  output logic               mem_timeout,
  output logic               halted,
  output logic [COUNT_W-1:0] stall_cycles,
  output logic [COUNT_W-1:0] flush_count
);

  localparam int              WCW       = wait_cnt_width(MAX_WAIT);
  localparam logic [WCW-1:0]  WAIT_LAST = WCW'(MAX_WAIT - 1);

  ctrl_state_e    state_q, state_d;
  logic [WCW-1:0] wait_q, wait_d;

  logic taken, mem_busy, load_use;
  logic freeze, branch_fire, bubble, timeout_pulse, in_halt;

  assign taken    = em_branch & em_zero;
  assign mem_busy = em_mem_access & ~dmem_ready;
  assign load_use = ie_memread & (ie_rd != 5'd0) &
                    ((ie_rd == id_rs1) | (id_uses_rs2 & (ie_rd == id_rs2)));

  always_comb begin
    state_d       = state_q;
    wait_d        = wait_q;
    freeze        = 1'b0;
    branch_fire   = 1'b0;
    bubble        = 1'b0;
    timeout_pulse = 1'b0;
    in_halt       = 1'b0;
    unique case (state_q)
      RUN: begin
        if (mem_busy) begin
          freeze  = 1'b1;
          state_d = MEM_WAIT;
          wait_d  = '0;
        end else if (taken) begin
          branch_fire = 1'b1;
        end else if (load_use) begin
          bubble = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (dmem_ready) begin
          state_d = RUN;
          if (taken) begin
            branch_fire = 1'b1;
          end else if (load_use) begin
            bubble = 1'b1;
          end
        end else if (wait_q == WAIT_LAST) begin
          freeze        = 1'b1;
          timeout_pulse = 1'b1;
          state_d       = HALT;
        end else begin
          freeze = 1'b1;
          wait_d = wait_q + 1'b1;
        end
      end
      HALT: begin
        freeze  = 1'b1;
        in_halt = 1'b1;
      end
      default: begin
        freeze  = 1'b1;
        state_d = RUN;
        wait_d  = '0;
      end
    endcase
  end

  // Reset wins over every rule: pipeline held and cleared while reset is high
  always_comb begin
    pc_write      = ~freeze & ~bubble;
    pc_sel_branch = branch_fire;
    if_id_write   = ~freeze & ~bubble;
    if_id_flush   = branch_fire;
    id_ex_write   = ~freeze;
    id_ex_flush   = branch_fire | bubble;
    ex_mem_write  = ~freeze;
    ex_mem_flush  = branch_fire;
    mem_wb_write  = ~freeze;
    mem_timeout   = timeout_pulse;
    halted        = in_halt;
    if (reset) begin
      pc_write      = 1'b0;
      pc_sel_branch = 1'b0;
      if_id_write   = 1'b0;
      if_id_flush   = 1'b1;
      id_ex_write   = 1'b0;
      id_ex_flush   = 1'b1;
      ex_mem_write  = 1'b0;
      ex_mem_flush  = 1'b1;
      mem_wb_write  = 1'b0;
      mem_timeout   = 1'b0;
      halted        = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  logic stall_inc, flush_inc;
  assign stall_inc = ~reset & ~pc_write;
  assign flush_inc = ~reset & branch_fire;

  hazard_sat_counter #(.W(COUNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (stall_inc),
    .count (stall_cycles)
  );

  hazard_sat_counter #(.W(COUNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (flush_inc),
    .count (flush_count)
  );

endmodule : pipeline_hazard_ctrl

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl (MAX_WAIT=4, COUNT_W=4) with an
// expected-control scoreboard and counter checks after each clock edge.
module tb_pipeline_hazard_ctrl;

  localparam int CW = 4;

  // {pc_write, pc_sel_branch, if_id_write, if_id_flush, id_ex_write, id_ex_flush,
  //  ex_mem_write, ex_mem_flush, mem_wb_write, mem_timeout, halted}
  localparam logic [10:0] CTL_RUN  = 11'b1_0_1_0_1_0_1_0_1_0_0;
  localparam logic [10:0] CTL_RST  = 11'b0_0_0_1_0_1_0_1_0_0_0;
  localparam logic [10:0] CTL_LU   = 11'b0_0_0_0_1_1_1_0_1_0_0;
  localparam logic [10:0] CTL_BR   = 11'b1_1_1_1_1_1_1_1_1_0_0;
  localparam logic [10:0] CTL_FRZ  = 11'b0_0_0_0_0_0_0_0_0_0_0;
  localparam logic [10:0] CTL_TO   = 11'b0_0_0_0_0_0_0_0_0_1_0;
  localparam logic [10:0] CTL_HALT = 11'b0_0_0_0_0_0_0_0_0_0_1;

  logic          clk = 1'b0;
  logic          reset;
  logic [4:0]    id_rs1, id_rs2, ie_rd;
  logic          id_uses_rs2, ie_memread, em_branch, em_zero, em_mem_access, dmem_ready;
  logic          pc_write, pc_sel_branch, if_id_write, if_id_flush, id_ex_write, id_ex_flush;
  logic          ex_mem_write, ex_mem_flush, mem_wb_write, mem_timeout, halted;
  logic [CW-1:0] stall_cycles, flush_count;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    string       tag;
    logic [10:0] ctl;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.MAX_WAIT(4), .COUNT_W(CW)) dut (
    .clk           (clk),
    .reset         (reset),
    .id_rs1        (id_rs1),
    .id_rs2        (id_rs2),
    .id_uses_rs2   (id_uses_rs2),
    .ie_memread    (ie_memread),
    .ie_rd         (ie_rd),
    .em_branch     (em_branch),
    .em_zero       (em_zero),
    .em_mem_access (em_mem_access),
    .dmem_ready    (dmem_ready),
    .pc_write      (pc_write),
    .pc_sel_branch (pc_sel_branch),
    .if_id_write   (if_id_write),
    .if_id_flush   (if_id_flush),
    .id_ex_write   (id_ex_write),
    .id_ex_flush   (id_ex_flush),
    .ex_mem_write  (ex_mem_write),
    .ex_mem_flush  (ex_mem_flush),
    .mem_wb_write  (mem_wb_write),
    .mem_timeout   (mem_timeout),
    .halted        (halted),
    .stall_cycles  (stall_cycles),
    .flush_count   (flush_count)
  );

  task automatic drive(input logic rst, input logic mr, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic u2,
                       input logic br, input logic z, input logic acc, input logic rdy);
    reset = rst; ie_memread = mr; ie_rd = rd; id_rs1 = rs1; id_rs2 = rs2;
    id_uses_rs2 = u2; em_branch = br; em_zero = z; em_mem_access = acc; dmem_ready = rdy;
  endtask

  task automatic idle(input logic rst);
    drive(rst, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  // Push the expected controls, sample mid-cycle, pop and compare, then clock.
  task automatic step(input string tag, input logic [10:0] ctl);
    exp_t e, got;
    logic [10:0] obs;
    e.tag = tag;
    e.ctl = ctl;
    sb.push_back(e);
    #4;
    obs = {pc_write, pc_sel_branch, if_id_write, if_id_flush, id_ex_write, id_ex_flush,
           ex_mem_write, ex_mem_flush, mem_wb_write, mem_timeout, halted};
    got = sb.pop_front();
    n_cmp++;
    assert (obs === got.ctl)
      else begin
        n_bad++;
        $error("FAIL %s ctl observed=%b expected=%b", got.tag, obs, got.ctl);
      end
    $display("step %-14s ctl=%b stall=%0d flush=%0d", got.tag, obs, stall_cycles, flush_count);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_cnt(input string tag, input logic [CW-1:0] stall_exp,
                         input logic [CW-1:0] flush_exp);
    n_cmp++;
    assert (stall_cycles === stall_exp)
      else begin
        n_bad++;
        $error("FAIL %s stall_cycles observed=%0d expected=%0d", tag, stall_cycles, stall_exp);
      end
    n_cmp++;
    assert (flush_count === flush_exp)
      else begin
        n_bad++;
        $error("FAIL %s flush_count observed=%0d expected=%0d", tag, flush_count, flush_exp);
      end
  endtask

  initial begin
    idle(1'b1);
    @(posedge clk);
    #1;
    step("reset_hold", CTL_RST);
    chk_cnt("reset_cnt", 4'd0, 4'd0);

    idle(1'b0);
    step("run_idle", CTL_RUN);
    chk_cnt("idle_cnt", 4'd0, 4'd0);

    // Load-use via rs1, then the same with rd=x0
    drive(1'b0, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step("lu_rs1", CTL_LU);
    chk_cnt("lu_rs1_cnt", 4'd1, 4'd0);
    drive(1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    step("lu_rd0", CTL_RUN);
    chk_cnt("lu_rd0_cnt", 4'd1, 4'd0);

    // Load-use via rs2 only when rs2 is actually read
    drive(1'b0, 1'b1, 5'd7, 5'd3, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    step("lu_rs2", CTL_LU);
    drive(1'b0, 1'b1, 5'd7, 5'd3, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step("lu_rs2_unused", CTL_RUN);
    chk_cnt("lu_rs2_cnt", 4'd2, 4'd0);

    // Taken branch squashes a coincident load-use
    drive(1'b0, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    step("br_over_lu", CTL_BR);
    chk_cnt("br_cnt", 4'd2, 4'd1);
    drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    step("br_not_taken", CTL_RUN);

    // Memory wait: detect + 3 waiting cycles frozen, then ready
    drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step("mw_detect", CTL_FRZ);
    for (int i = 0; i < 3; i++) step("mw_wait", CTL_FRZ);
    chk_cnt("mw_cnt", 4'd6, 4'd1);
    drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    step("mw_ready", CTL_RUN);
    idle(1'b0);
    step("mw_back_run", CTL_RUN);
    chk_cnt("mw_done_cnt", 4'd6, 4'd1);

    // Branch resolving in the cycle the wait ends
    drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step("mwb_detect", CTL_FRZ);
    drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    step("mwb_ready_br", CTL_BR);
    chk_cnt("mwb_cnt", 4'd7, 4'd2);

    // Timeout: pulse in 4th waiting cycle, then HALT; stall counter saturates
    drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step("to_detect", CTL_FRZ);
    for (int i = 0; i < 3; i++) step("to_wait", CTL_FRZ);
    step("to_pulse", CTL_TO);
    chk_cnt("to_cnt", 4'd12, 4'd2);
    drive(1'b0, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) step("halt", CTL_HALT);
    chk_cnt("halt_sat_cnt", 4'd15, 4'd2);

    idle(1'b1);
    step("halt_reset", CTL_RST);
    chk_cnt("halt_reset_cnt", 4'd0, 4'd0);
    idle(1'b0);
    step("post_halt_run", CTL_RUN);

    // Reset in MEM_WAIT discards progress: a fresh wait gets the full budget
    drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step("rmw_detect", CTL_FRZ);
    step("rmw_wait", CTL_FRZ);
    step("rmw_wait", CTL_FRZ);
    reset = 1'b1;
    step("rmw_reset", CTL_RST);
    idle(1'b0);
    step("rmw_run", CTL_RUN);
    chk_cnt("rmw_cnt", 4'd0, 4'd0);
    drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step("rmw2_detect", CTL_FRZ);
    for (int i = 0; i < 3; i++) step("rmw2_wait", CTL_FRZ);
    dmem_ready = 1'b1;
    step("rmw2_ready", CTL_RUN);
    chk_cnt("rmw2_cnt", 4'd4, 4'd0);

    // Held load-use: stall counter stops at all-ones
    drive(1'b0, 1'b1, 5'd9, 5'd9, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) step("lu_hold", CTL_LU);
    chk_cnt("sat_cnt", 4'd15, 4'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_pipeline_hazard_ctrl

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central hazard and sequencing controller for the 5-stage pipelined RISC-V core. It drives the write-enable and flush controls of the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It covers load-use stalls, taken-branch flushes (branch resolves in MEM from EX/MEM Branch/Zero), and multi-cycle data-memory waits with a timeout. It also keeps saturating stall and flush performance counters.

Parameters:
MAX_WAIT, 16, max cycles spent in MEM_WAIT before timeout (>=1)
COUNT_W, 32, width of performance counters

Ports:
clk  input  1  core clock, rising edge
reset  input  1  synchronous, active-high
id_rs1  input  5  rs1 of instruction in IF/ID
id_rs2  input  5  rs2 of instruction in IF/ID
id_uses_rs2  input  1  IF/ID instruction reads rs2
ie_memread  input  1  ID/EX MemRead
ie_rd  input  5  ID/EX destination register
em_branch  input  1  EX/MEM Branch
em_zero  input  1  EX/MEM Zero
em_mem_access  input  1  EX/MEM MemRead OR MemWrite
dmem_ready  input  1  data memory completes access this cycle
pc_write  output  1  PC load enable
pc_sel_branch  output  1  PC takes EX/MEM adder target
if_id_write  output  1  IF/ID load enable
if_id_flush  output  1  IF/ID cleared to NOP
id_ex_write  output  1  ID/EX load enable
id_ex_flush  output  1  ID/EX control bits cleared (bubble)
ex_mem_write  output  1  EX/MEM load enable
ex_mem_flush  output  1  EX/MEM control bits cleared
mem_wb_write  output  1  MEM/WB load enable
mem_timeout  output  1  pulse: wait limit reached
halted  output  1  controller in HALT
stall_cycles  output  COUNT_W  saturating count of cycles with pc_write=0
flush_count  output  COUNT_W  saturating count of taken-branch flushes

Behaviour:
- Clock is clk; reset is synchronous, active-high. Sampled at the rising edge: state<=RUN, wait_cnt<=0, both counters<=0.
- While reset=1, outputs are forced: all *_write=0, all *_flush=1, pc_sel_branch=0, mem_timeout=0, halted=0.
- Control outputs are combinational from the state and current inputs (zero latency). The state, wait_cnt and counters are registered.
- Derived signals:
  - taken = em_branch & em_zero
  - mem_busy = em_mem_access & ~dmem_ready
  - load_use = ie_memread & (ie_rd!=0) & ((ie_rd==id_rs1) | (id_uses_rs2 & ie_rd==id_rs2))
- Defaults: all *_write=1, all *_flush=0, pc_sel_branch=0.
- State RUN, priority mem_busy > taken > load_use:
  - mem_busy: freeze (all *_write=0, no flush); next MEM_WAIT with wait_cnt<=0.
  - taken: pc_sel_branch=1, if_id_flush=id_ex_flush=ex_mem_flush=1; flush_count++. The taken case also squashes any simultaneous load_use.
  - load_use: pc_write=0, if_id_write=0, id_ex_flush=1. This is a single bubble cycle; the next cycle re-evaluates.
- State MEM_WAIT:
  - dmem_ready=1: freeze lifted. The RUN taken/load_use rules apply this cycle; next RUN.
  - dmem_ready=0 and wait_cnt==MAX_WAIT-1: freeze, mem_timeout=1 for this cycle; next HALT.
  - otherwise: freeze, wait_cnt++.
- State HALT: freeze, halted=1. Exit only by reset. Inputs are ignored.
- Counters:
  - stall_cycles increments on every non-reset cycle with pc_write=0, including load-use, MEM_WAIT, HALT and the RUN cycle that detects mem_busy.
  - Both counters saturate at all-ones and never wrap.
- Reset mid-MEM_WAIT or in HALT returns to RUN next cycle and discards wait progress.
- ie_rd==0 never triggers a stall.
- Unused state encodings recover to RUN.

Decomposition:
- Package pipeline_ctrl_pkg holds:
  - state enum {RUN, MEM_WAIT, HALT}, 2-bit
  - WAIT_CNT_W = $clog2(MAX_WAIT) (min 1)
  - NOP instruction constant shared with the flush logic
- Sub-module hazard_sat_counter (parameter W; inputs clk, reset, inc; output count) is instantiated twice for the performance counters.

Test Plan:
- Load-use: ie_memread=1, ie_rd=5, id_rs1=5 in RUN → one cycle of pc_write=0, if_id_write=0, id_ex_flush=1; stall_cycles=1. Same with ie_rd=0 → no stall.
- Taken branch coincident with load_use: em_branch=1, em_zero=1 → pc_sel_branch=1 and three flushes, pc_write=1, no load-use bubble; flush_count=1.
- Memory wait: em_mem_access=1, dmem_ready low 3 cycles then high → 4 frozen cycles, then RUN. Writes resume in the ready cycle; stall_cycles=4.
- Timeout with MAX_WAIT=4: dmem_ready held low → mem_timeout pulses in the 4th MEM_WAIT cycle, then halted=1 and freeze persists; reset → RUN, counters 0.
- Reset during MEM_WAIT → next cycle RUN, all writes 1, wait progress lost. During reset cycles, flushes=1 and writes=0.
- Saturation with COUNT_W=4: hold load_use for 20 cycles → stall_cycles stops at 15.
